// File: rtl/stream_demux15.sv
// stream_demux15: single-register 1-to-5 stream demultiplexer.
// A 3-bit select code is decoded at acceptance into a destination index 0..4.
// The beat is presented on the shared out_data with a one-hot out_valid.
// Optional feature macro: STREAM_DEMUX15_CNT_EN
// - Defined: five 16-bit wrapping per-destination transfer counters on xfer_cnt.
// - Undefined: xfer_cnt is tied to zero and no counter flops exist.
module stream_demux15 #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [2:0]       in_sel,
    output logic [WIDTH-1:0] out_data,
    output logic [4:0]       out_valid,
    input  logic [4:0]       out_ready,
    output logic [79:0]      xfer_cnt
);

    logic             full_q, full_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [2:0]       dest_q, dest_d;
    logic [2:0]       sel_dest;
    logic             out_fire;
    logic             in_fire;

    // One-hot valid: only the stored destination can see a valid beat.
    genvar gi;
    generate
        for (gi = 0; gi < 5; gi++) begin : g_valid
            assign out_valid[gi] = full_q && (dest_q == 3'(gi));
        end
    endgenerate

    // out_valid already masks out the non-selected ready bits.
    assign out_fire = |(out_valid & out_ready);
    assign in_ready = !full_q || out_fire;
    assign in_fire  = in_valid && in_ready;
    assign out_data = data_q;

    // Decode the raw select code into a destination index; only the index is stored.
    always_comb begin
        sel_dest = 3'd4;
        casez (in_sel)
            3'b000:  sel_dest = 3'd0;
            3'b001:  sel_dest = 3'd1;
            3'b01?:  sel_dest = 3'd2;
            3'b10?:  sel_dest = 3'd3;
            default: sel_dest = 3'd4;
        endcase
    end

    // Next-state of the output register: load on in-fire, drain on out-fire only.
    always_comb begin
        full_d = full_q;
        data_d = data_q;
        dest_d = dest_q;
        if (in_fire) begin
            full_d = 1'b1;
            data_d = in_data;
            dest_d = sel_dest;
        end else if (out_fire) begin
            full_d = 1'b0;
        end
    end

    // Output register with asynchronous clear; a held beat is simply dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q <= 1'b0;
            data_q <= '0;
            dest_q <= 3'd0;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
            dest_q <= dest_d;
        end
    end

`ifdef STREAM_DEMUX15_CNT_EN
    generate
        for (gi = 0; gi < 5; gi++) begin : g_cnt
            logic [15:0] cnt_q, cnt_d;

            // Count completed transfers to this destination, wrapping at 16 bits.
            always_comb begin
                cnt_d = cnt_q;
                if (out_fire && (dest_q == 3'(gi))) begin
                    cnt_d = cnt_q + 16'd1;
                end
            end

            // Counter flop, cleared with the rest of the state.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_q <= 16'd0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end

            assign xfer_cnt[16*gi +: 16] = cnt_q;
        end
    endgenerate
`else
    assign xfer_cnt = '0;
`endif

endmodule
